// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory bundle for the multi-cycle MIPS controller.
// master: the controller (drives strobes/selects); slave: datapath + memory.
//
// Memory handshake: the controller holds MemRead or MemWrite (with IorD)
// steady for as long as an access is outstanding. The memory raises
// mem_ready in the cycle the access completes. That cycle is the last
// cycle of the access, and the controller moves on at the following edge.
// There is no separate request pulse, and mem_ready is ignored whenever
// neither MemRead nor MemWrite is high.
interface multicycle_control_if #(
    parameter int STATE_W = 4
);
    logic [5:0]         Opcode;
    logic               mem_ready;
    logic               PCWrite;
    logic               PCWriteCond;
    logic               IorD;
    logic               MemRead;
    logic               MemWrite;
    logic               IRWrite;
    logic               RegWrite;
    logic               ALUsrcA;
    logic               Arith;
    logic [1:0]         RegDstn;
    logic [1:0]         MemtoReg;
    logic [1:0]         ALUsrcB;
    logic [1:0]         ALUop;
    logic [1:0]         PCSource;
    logic               instr_done;
    logic               halted;
    logic [STATE_W-1:0] state_dbg;

    modport master (
        input  Opcode, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               RegWrite, ALUsrcA, Arith, RegDstn, MemtoReg, ALUsrcB,
               ALUop, PCSource, instr_done, halted, state_dbg
    );

    modport slave (
        output Opcode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               RegWrite, ALUsrcA, Arith, RegDstn, MemtoReg, ALUsrcB,
               ALUop, PCSource, instr_done, halted, state_dbg
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS controller FSM. It sequences a shared datapath that has
// one memory port, one ALU (which also forms PC+4 and the branch target),
// and IR/ALUOut/MDR registers.
// Supported instructions: R-type, addi, lw, sw, andi, beq and jal.
// Control encodings match the single-cycle control unit.
// Optional macro MCU_ILLEGAL_HALT_EN: an illegal opcode parks the FSM in
// HALT, with halted=1, until rst. Without the macro, an illegal opcode is
// executed as a NOP.
module multicycle_control #(
    parameter int         STATE_W = 4,
    parameter logic [5:0] OP_R    = 6'b000000,
    parameter logic [5:0] OP_ADDI = 6'b001000,
    parameter logic [5:0] OP_LW   = 6'b100011,
    parameter logic [5:0] OP_SW   = 6'b101011,
    parameter logic [5:0] OP_ANDI = 6'b001100,
    parameter logic [5:0] OP_BEQ  = 6'b000100,
    parameter logic [5:0] OP_JAL  = 6'b000011
) (
    input logic                  clk,
    input logic                  rst,
    multicycle_control_if.master bus
);

    typedef enum logic [STATE_W-1:0] {
        FETCH  = STATE_W'(0),
        DECODE = STATE_W'(1),
        MEMADR = STATE_W'(2),
        MEMRD  = STATE_W'(3),
        MEMWB  = STATE_W'(4),
        MEMWR  = STATE_W'(5),
        EXEC_R = STATE_W'(6),
        RWB    = STATE_W'(7),
        EXEC_I = STATE_W'(8),
        IWB    = STATE_W'(9),
        BRANCH = STATE_W'(10),
`ifdef MCU_ILLEGAL_HALT_EN
        JAL    = STATE_W'(11),
        HALT   = STATE_W'(12)
`else
        JAL    = STATE_W'(11)
`endif
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [5:0] op_q;

    assign bus.state_dbg = state_q;

    // State register and opcode latch. The opcode is captured in DECODE,
    // because the later states need it after IR may no longer be trusted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE) begin
                op_q <= bus.Opcode;
            end
        end
    end

    // Next-state and Moore control decode. rst masks every output to 0.
    always_comb begin
        state_d         = FETCH;
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.ALUsrcA     = 1'b0;
        bus.Arith       = 1'b0;
        bus.RegDstn     = 2'b00;
        bus.MemtoReg    = 2'b00;
        bus.ALUsrcB     = 2'b00;
        bus.ALUop       = 2'b00;
        bus.PCSource    = 2'b00;
        bus.instr_done  = 1'b0;
        bus.halted      = 1'b0;
        if (!rst) begin
            case (state_q)
                FETCH: begin
                    // IR load and PC+4 commit only in the cycle the read completes.
                    bus.MemRead = 1'b1;
                    bus.ALUsrcB = 2'b01;
                    bus.IRWrite = bus.mem_ready;
                    bus.PCWrite = bus.mem_ready;
                    state_d     = bus.mem_ready ? DECODE : FETCH;
                end
                DECODE: begin
                    // The ALU speculatively forms the branch target while the opcode is decoded.
                    bus.ALUsrcB = 2'b11;
                    case (bus.Opcode)
                        OP_LW, OP_SW:     state_d = MEMADR;
                        OP_R:             state_d = EXEC_R;
                        OP_ADDI, OP_ANDI: state_d = EXEC_I;
                        OP_BEQ:           state_d = BRANCH;
                        OP_JAL:           state_d = JAL;
                        default: begin
`ifdef MCU_ILLEGAL_HALT_EN
                            state_d = HALT;
`else
                            state_d        = FETCH;
                            bus.instr_done = 1'b1;
`endif
                        end
                    endcase
                end
                MEMADR: begin
                    bus.ALUsrcA = 1'b1;
                    bus.ALUsrcB = 2'b10;
                    bus.Arith   = 1'b1;
                    state_d     = (op_q == OP_SW) ? MEMWR : MEMRD;
                end
                MEMRD: begin
                    bus.MemRead = 1'b1;
                    bus.IorD    = 1'b1;
                    state_d     = bus.mem_ready ? MEMWB : MEMRD;
                end
                MEMWB: begin
                    bus.MemtoReg   = 2'b01;
                    bus.RegWrite   = 1'b1;
                    bus.instr_done = 1'b1;
                end
                MEMWR: begin
                    // The store retires in the cycle the memory accepts it.
                    bus.MemWrite   = 1'b1;
                    bus.IorD       = 1'b1;
                    bus.instr_done = bus.mem_ready;
                    state_d        = bus.mem_ready ? FETCH : MEMWR;
                end
                EXEC_R: begin
                    bus.ALUsrcA = 1'b1;
                    bus.ALUop   = 2'b10;
                    state_d     = RWB;
                end
                RWB: begin
                    bus.RegDstn    = 2'b01;
                    bus.RegWrite   = 1'b1;
                    bus.instr_done = 1'b1;
                end
                EXEC_I: begin
                    bus.ALUsrcA = 1'b1;
                    bus.ALUsrcB = 2'b10;
                    if (op_q == OP_ANDI) begin
                        bus.ALUop = 2'b11;
                    end else begin
                        bus.Arith = 1'b1;
                    end
                    state_d = IWB;
                end
                IWB: begin
                    bus.RegWrite   = 1'b1;
                    bus.instr_done = 1'b1;
                end
                BRANCH: begin
                    bus.ALUsrcA     = 1'b1;
                    bus.ALUop       = 2'b01;
                    bus.Arith       = 1'b1;
                    bus.PCWriteCond = 1'b1;
                    bus.PCSource    = 2'b01;
                    bus.instr_done  = 1'b1;
                end
                JAL: begin
                    // PC already holds PC+4 from FETCH, and that is the link value written to $ra.
                    bus.RegDstn    = 2'b10;
                    bus.MemtoReg   = 2'b10;
                    bus.RegWrite   = 1'b1;
                    bus.PCWrite    = 1'b1;
                    bus.PCSource   = 2'b10;
                    bus.instr_done = 1'b1;
                end
`ifdef MCU_ILLEGAL_HALT_EN
                HALT: begin
                    bus.halted = 1'b1;
                    state_d    = HALT;
                end
`endif
                default: state_d = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control.
// A reactive memory model answers accesses after queued wait counts.
// A per-instruction reference (latency, strobe counts, key selects) is
// pushed into a scoreboard when stimulus is generated, and a monitor
// compares against it at each instr_done.
`timescale 1ns/1ps
module tb_multicycle_control;

    localparam int         STATE_W = 4;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_JAL  = 6'b000011;

    typedef struct packed {
        logic [7:0] cycles;
        logic [7:0] n_rd;
        logic [7:0] n_wr;
        logic [3:0] n_rw;
        logic [3:0] n_ir;
        logic [3:0] n_pcw;
        logic [3:0] n_pcwc;
        logic [3:0] wb_sel;
        logic [4:0] alu_sig;
        logic [1:0] pcsrc;
        logic [3:0] fstate;
    } rec_t;
    localparam int REC_W = $bits(rec_t);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicycle_control_if #(.STATE_W(STATE_W)) bus ();

    multicycle_control #(.STATE_W(STATE_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ---------------- shared state ----------------
    logic [REC_W-1:0] exp_q[$];
    logic [5:0]       op_stim[$];
    int               wait_q[$];
    int               checks = 0;
    int               errors = 0;
    bit               mon_en = 1'b0;
    logic [5:0]       legal[7] = '{OP_R, OP_ADDI, OP_LW, OP_SW, OP_ANDI, OP_BEQ, OP_JAL};

    function automatic logic [20:0] out_vec();
        return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                bus.IRWrite, bus.RegWrite, bus.ALUsrcA, bus.Arith, bus.RegDstn,
                bus.MemtoReg, bus.ALUsrcB, bus.ALUop, bus.PCSource, bus.instr_done,
                bus.halted};
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        for (int i = 0; i < 7; i++) if (legal[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Reference model: what one instruction looks like from the outside.
    function automatic rec_t model(input logic [5:0] op, input int fw, input int dw);
        rec_t r;
        r        = '0;
        r.cycles = 8'(fw + 1);
        r.n_rd   = 8'(fw + 1);
        r.n_ir   = 4'd1;
        r.n_pcw  = 4'd1;
        case (op)
            OP_LW: begin
                r.cycles += 8'(dw + 4); r.n_rd += 8'(dw + 1); r.n_rw = 4'd1;
                r.wb_sel = 4'b0001; r.alu_sig = 5'b00110; r.fstate = 4'd4;
            end
            OP_SW: begin
                r.cycles += 8'(dw + 3); r.n_wr = 8'(dw + 1);
                r.alu_sig = 5'b00110; r.fstate = 4'd5;
            end
            OP_R: begin
                r.cycles += 8'd3; r.n_rw = 4'd1; r.wb_sel = 4'b0100;
                r.alu_sig = 5'b10000; r.fstate = 4'd7;
            end
            OP_ADDI: begin
                r.cycles += 8'd3; r.n_rw = 4'd1; r.wb_sel = 4'b0000;
                r.alu_sig = 5'b00110; r.fstate = 4'd9;
            end
            OP_ANDI: begin
                r.cycles += 8'd3; r.n_rw = 4'd1; r.wb_sel = 4'b0000;
                r.alu_sig = 5'b11010; r.fstate = 4'd9;
            end
            OP_BEQ: begin
                r.cycles += 8'd2; r.n_pcwc = 4'd1; r.alu_sig = 5'b01100;
                r.pcsrc = 2'b01; r.fstate = 4'd10;
            end
            OP_JAL: begin
                r.cycles += 8'd2; r.n_rw = 4'd1; r.n_pcw = 4'd2;
                r.wb_sel = 4'b1010; r.pcsrc = 2'b10; r.fstate = 4'd11;
            end
            default: begin
                r.cycles += 8'd1; r.fstate = 4'd1;
            end
        endcase
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic push_instr(input logic [5:0] op, input int fw, input int dw);
        op_stim.push_back(op);
        wait_q.push_back(fw);
        if (op == OP_LW || op == OP_SW) wait_q.push_back(dw);
        exp_q.push_back(model(op, fw, dw));
    endtask

    task automatic check_zero(input string name, input logic [20:0] mask);
        checks++;
        if ((out_vec() & mask) != '0) begin
            errors++;
            $display("FAIL %s: outputs=%h required 0 (mask %h)", name, out_vec(), mask);
        end
    endtask

    task automatic check_state(input string name, input logic [STATE_W-1:0] st);
        checks++;
        if (bus.state_dbg !== st) begin
            errors++;
            $display("FAIL %s: state_dbg=%0d required %0d", name, bus.state_dbg, st);
        end
    endtask

    // ---------------- reactive memory ----------------
    bit in_acc;
    bit acc_fetch;
    int wcnt;
    initial begin
        bus.Opcode    = '0;
        bus.mem_ready = 1'b0;
        in_acc        = 1'b0;
        acc_fetch     = 1'b0;
        wcnt          = 0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                bus.mem_ready = 1'b1;
                in_acc        = 1'b0;
            end else if (bus.MemRead || bus.MemWrite) begin
                if (!in_acc) begin
                    in_acc    = 1'b1;
                    acc_fetch = !bus.IorD;
                    wcnt      = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
                end
                if (wcnt > 0) begin
                    bus.mem_ready = 1'b0;
                    wcnt--;
                end else begin
                    bus.mem_ready = 1'b1;
                    in_acc        = 1'b0;
                    if (acc_fetch && op_stim.size() > 0) bus.Opcode = op_stim.pop_front();
                end
            end else begin
                bus.mem_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    int         cyc = 0, rd = 0, wr = 0, rw = 0, ir = 0, pcw = 0, pcwc = 0, n_instr = 0;
    logic [3:0] wb = '0;
    logic [4:0] alu = '0;
    logic [1:0] pcs = '0;
    initial begin
        rec_t got;
        rec_t exp;
        forever begin
            @(negedge clk);
            #3;
            if (mon_en) begin
                cyc++;
                if (cyc == 1) begin
                    checks++;
                    if (bus.state_dbg != '0 || !bus.MemRead) begin
                        errors++;
                        $display("FAIL instr_start_%0d: state_dbg=%0d MemRead=%b required 0/1",
                                 n_instr, bus.state_dbg, bus.MemRead);
                    end
                end
                if (bus.MemRead)  rd++;
                if (bus.MemWrite) wr++;
                if (bus.RegWrite) begin rw++; wb = {bus.RegDstn, bus.MemtoReg}; end
                if (bus.IRWrite)  ir++;
                if (bus.PCWrite)  pcw++;
                if (bus.PCWriteCond) pcwc++;
                if (bus.ALUsrcA) alu = {bus.ALUop, bus.Arith, bus.ALUsrcB};
                if ((bus.PCWrite || bus.PCWriteCond) && !bus.IRWrite) pcs = bus.PCSource;
                checks++;
                if ((bus.MemRead && bus.MemWrite) || (bus.RegWrite && bus.MemWrite) || bus.halted) begin
                    errors++;
                    $display("FAIL exclusive_strobes: MemRead=%b MemWrite=%b RegWrite=%b halted=%b required no overlap, halted 0",
                             bus.MemRead, bus.MemWrite, bus.RegWrite, bus.halted);
                end
                if (bus.instr_done) begin
                    got = '{cycles: 8'(cyc), n_rd: 8'(rd), n_wr: 8'(wr), n_rw: 4'(rw),
                            n_ir: 4'(ir), n_pcw: 4'(pcw), n_pcwc: 4'(pcwc), wb_sel: wb,
                            alu_sig: alu, pcsrc: pcs, fstate: 4'(bus.state_dbg)};
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_done: instr_done seen with empty queue, required none");
                    end else begin
                        exp = exp_q.pop_front();
                        if (got !== exp) begin
                            errors++;
                            $display("FAIL instr_%0d: got cyc=%0d rd=%0d wr=%0d rw=%0d ir=%0d pcw=%0d pcwc=%0d wb=%b alu=%b pcs=%b st=%0d required cyc=%0d rd=%0d wr=%0d rw=%0d ir=%0d pcw=%0d pcwc=%0d wb=%b alu=%b pcs=%b st=%0d",
                                     n_instr, got.cycles, got.n_rd, got.n_wr, got.n_rw, got.n_ir, got.n_pcw,
                                     got.n_pcwc, got.wb_sel, got.alu_sig, got.pcsrc, got.fstate,
                                     exp.cycles, exp.n_rd, exp.n_wr, exp.n_rw, exp.n_ir, exp.n_pcw,
                                     exp.n_pcwc, exp.wb_sel, exp.alu_sig, exp.pcsrc, exp.fstate);
                        end
                    end
                    n_instr++;
                    cyc = 0; rd = 0; wr = 0; rw = 0; ir = 0; pcw = 0; pcwc = 0;
                    wb = '0; alu = '0; pcs = '0;
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int         budget;
        bit         seen;
        logic [5:0] op;
        rst = 1'b1;

        // Directed instructions, then random ones.
        push_instr(OP_LW, 0, 0);
        push_instr(OP_SW, 0, 3);
        push_instr(OP_R, 0, 0);
        push_instr(OP_ADDI, 0, 0);
        push_instr(OP_ANDI, 0, 0);
        push_instr(OP_BEQ, 0, 0);
        push_instr(OP_JAL, 0, 0);
        push_instr(OP_R, 2, 0);
`ifndef MCU_ILLEGAL_HALT_EN
        push_instr(6'b111111, 0, 0);
`endif
        for (int i = 0; i < 40; i++) begin
`ifdef MCU_ILLEGAL_HALT_EN
            op = legal[$urandom_range(0, 6)];
`else
            if ($urandom_range(0, 7) == 7) begin
                do op = 6'($urandom_range(0, 63)); while (is_legal(op));
            end else begin
                op = legal[$urandom_range(0, 6)];
            end
`endif
            push_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        // Reset: two cycles, outputs forced low even with mem_ready high.
        repeat (2) begin
            @(negedge clk);
            #3;
            check_zero("reset_outputs", '1);
            check_state("reset_state", '0);
        end
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;

        budget = 0;
        while (exp_q.size() > 0 && budget < 5000) begin
            @(negedge clk);
            budget++;
        end
        mon_en = 1'b0;
        checks++;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d instructions outstanding, required 0", exp_q.size());
        end

        // Reset during MEMRD of a lw: abandoned, with no register write.
        @(negedge clk);
        rst = 1'b1;
        op_stim.delete();
        wait_q.delete();
        @(negedge clk);
        rst = 1'b0;
        op_stim.push_back(OP_LW);
        wait_q.push_back(0);
        wait_q.push_back(10);
        seen   = 1'b0;
        budget = 0;
        while (budget < 20) begin
            @(negedge clk);
            #3;
            if (bus.state_dbg == 4'd3) begin
                seen = 1'b1;
                break;
            end
            budget++;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL reach_memrd: state 3 seen=%b required 1", seen);
        end
        @(negedge clk);
        rst = 1'b1;
        #3;
        check_zero("midrst_outputs_a", '1);
        @(negedge clk);
        #3;
        check_zero("midrst_outputs_b", '1);
        check_state("midrst_state", '0);
        @(negedge clk);
        rst = 1'b0;
        #3;
        check_state("post_rst_fetch", '0);
        for (int i = 0; i < 3; i++) begin
            check_zero("post_rst_no_regwrite", 21'h1 << 14);
            @(negedge clk);
            #3;
        end

`ifdef MCU_ILLEGAL_HALT_EN
        // Illegal opcode parks in HALT until reset.
        @(negedge clk);
        rst = 1'b1;
        op_stim.delete();
        wait_q.delete();
        @(negedge clk);
        rst = 1'b0;
        op_stim.push_back(6'b111111);
        wait_q.push_back(0);
        seen   = 1'b0;
        budget = 0;
        while (budget < 20) begin
            @(negedge clk);
            #3;
            if (bus.state_dbg == 4'd12) begin
                seen = 1'b1;
                break;
            end
            budget++;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL reach_halt: state 12 seen=%b required 1", seen);
        end
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (!bus.halted) begin
                errors++;
                $display("FAIL halted_hold: halted=%b required 1", bus.halted);
            end
            check_zero("halt_strobes", 21'h1ffffe);
            @(negedge clk);
            #3;
        end
        @(negedge clk);
        rst = 1'b1;
        #3;
        check_zero("halt_cleared", '1);
        @(negedge clk);
        rst = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
